turnstile_ctrl: RTL
===================

// Module: turnstile_ctrl
// PURPOSE
//   Parametrised metro turnstile lane controller, next generation of the single-lane gate FSM.
//   Latches a presented access code and range-checks it against [CODE_MIN, CODE_MAX].
//   Opens the door for a bounded time, closing early on a passage-sensor event.
//   Signals denial on bad codes; locks the lane after MAX_FAILS consecutive failures.
//   One instance per physical gate, driven by the ticket reader and passage sensor.
// PARAMETERS
//   CODE_W      4   width of access_code
//   CODE_MIN    4   lowest valid code (inclusive); must satisfy CODE_MIN <= CODE_MAX < 2**CODE_W
//   CODE_MAX    11  highest valid code (inclusive)
//   OPEN_CYCLES 16  door-open time in clk cycles, >= 1
//   DENY_CYCLES 4   deny indication time in cycles, >= 1
//   LOCK_CYCLES 32  lockout time in cycles, >= 1
//   MAX_FAILS   3   consecutive failures that trigger lockout, >= 1
//   PCNT_W      16  pass counter width (only with TURNSTILE_PASS_COUNT_EN)
// PORTS
//   clk              in   1       clock
//   rst              in   1       synchronous reset, active-high
//   validate_code    in   1       one-cycle request to check access_code
//   access_code      in   CODE_W  presented code, sampled when validate_code=1 in IDLE
//   pass_sensor      in   1       passenger detected through gate
//   open_access_door out  1       door open
//   deny_led         out  1       code rejected indication
//   lockout          out  1       lane locked
//   fail_count       out  fw      consecutive failures, fw = $clog2(MAX_FAILS+1)
//   state_out        out  3       current state (debug)
//   pass_count       out  PCNT_W  completed passages (TURNSTILE_PASS_COUNT_EN only)
// BEHAVIOUR
//   Reset (sync): state=IDLE, timer=0, code_q=0, fail_count=0, pass_count=0; all 1-bit outputs 0.
//   open_access_door, deny_led and lockout are decoded from state only (no input paths).
//   States: IDLE, CHECK, OPEN, DENY, LOCKOUT.
//   IDLE: validate_code=1 -> code_q<=access_code; next state CHECK.
//   CHECK (exactly 1 cycle):
//     CODE_MIN <= code_q <= CODE_MAX -> OPEN, fail_count<=0.
//     Otherwise fail_count+1; if that value == MAX_FAILS -> LOCKOUT, else DENY.
//   OPEN: door=1; timer counts from 0. Exit to IDLE after OPEN_CYCLES cycles
//     (timer==OPEN_CYCLES-1), or on the cycle after pass_sensor=1, whichever comes first.
//   DENY: deny_led=1 for DENY_CYCLES cycles, then IDLE. fail_count is held.
//   LOCKOUT: lockout=1 for LOCK_CYCLES cycles, then IDLE with fail_count<=0.
//   Timer clears on every state change. Width = $clog2(max(OPEN,DENY,LOCK)_CYCLES).
//   Latency: validate -> door high is 2 edges; total door-open time is exactly OPEN_CYCLES without sensor.
//   Boundaries:
//     validate_code outside IDLE is ignored, including during LOCKOUT.
//     access_code changes after sampling have no effect.
//     pass_sensor outside OPEN is ignored.
//     pass_sensor coincident with timer expiry is a single exit and counts as a passage.
//     rst mid-operation wins over all inputs; door closes on that edge.
//     Unreachable state encodings -> IDLE.
// CONFIGURATION
//   `define TURNSTILE_PASS_COUNT_EN:
//     with it: pass_count port exists; increments by 1 on each OPEN exit caused by
//       pass_sensor; saturates at all-ones.
//     without it: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package turnstile_pkg: state encodings (3-bit), state width constant, clog2/max helpers.
//   Sub-module turnstile_timer: cycle counter with clear, enable and terminal-count compare.
//   The FSM, code latch and fail/pass counters stay in turnstile_ctrl.
// TESTING (defaults)
//   1. validate, code=7, no sensor -> CHECK at edge 1; door=1 for 16 cycles; IDLE; fail_count=0.
//   2. code=7, pass_sensor on 5th open cycle -> door=0 next cycle; pass_count=1 (macro on).
//   3. codes 3, then 12 -> deny_led 4 cycles each, fail_count 1 then 2; then code 8 -> opens, fail_count=0.
//   4. codes 0, 15, 2 -> third enters LOCKOUT; lockout=1 for 32 cycles; validate mid-lockout ignored; fail_count=0 after.
//   5. codes 4 and 11 open; access_code changed to 0 the cycle after validate -> still opens.
//   6. rst=1 on 5th open cycle -> next edge door=0, state_out=IDLE, counters 0.

Source files
------------

// File: rtl/turnstile_pkg.sv
// Shared state encoding and elaboration-time helpers for the turnstile lane controller.
package turnstile_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_DENY    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/turnstile_timer.sv
// Up-counter with synchronous clear, count enable and terminal-count compare.
module turnstile_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/turnstile_ctrl.sv
// Turnstile lane controller: code check, timed door/deny/lockout phases, failure counting.
// Optional passage counter enabled by `define TURNSTILE_PASS_COUNT_EN.
module turnstile_ctrl
    import turnstile_pkg::*;
#(
    parameter int CODE_W      = 4,
    parameter int CODE_MIN    = 4,
    parameter int CODE_MAX    = 11,
    parameter int OPEN_CYCLES = 16,
    parameter int DENY_CYCLES = 4,
    parameter int LOCK_CYCLES = 32,
    parameter int MAX_FAILS   = 3,
    parameter int PCNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           validate_code,
    input  logic [CODE_W-1:0]              access_code,
    input  logic                           pass_sensor,
    output logic                           open_access_door,
    output logic                           deny_led,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic [STATE_W-1:0]             state_out
`ifdef TURNSTILE_PASS_COUNT_EN
    ,
    output logic [PCNT_W-1:0]              pass_count
`endif
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = f_max(1, f_clog2(f_max(f_max(OPEN_CYCLES, DENY_CYCLES), LOCK_CYCLES)));

    localparam logic [CODE_W-1:0] C_MIN   = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] C_MAX   = CODE_W'(CODE_MAX);
    localparam logic [FW-1:0]     F_LIMIT = FW'(MAX_FAILS);
    localparam logic [TW-1:0]     OPEN_TC = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]     DENY_TC = TW'(DENY_CYCLES - 1);
    localparam logic [TW-1:0]     LOCK_TC = TW'(LOCK_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CODE_W-1:0]   r_code;
    logic [FW-1:0]       r_fail;
    logic [FW-1:0]       w_fail_inc;
    logic                w_code_ok;
    logic                w_tc;
    logic                w_tmr_en;
    logic                w_tmr_clr;
    logic [TW-1:0]       w_term;

    assign w_code_ok  = (r_code >= C_MIN) && (r_code <= C_MAX);
    assign w_fail_inc = r_fail + 1'b1;

    // Timer restarts from zero whenever the state is about to change.
    assign w_tmr_clr = (w_next != r_state);

    turnstile_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .i_term (w_term),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_tmr_en = 1'b0;
        w_term   = '0;
        case (r_state)
            ST_IDLE: begin
                if (validate_code) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_code_ok) begin
                    w_next = ST_OPEN;
                end else if (w_fail_inc == F_LIMIT) begin
                    w_next = ST_LOCKOUT;
                end else begin
                    w_next = ST_DENY;
                end
            end
            ST_OPEN: begin
                w_tmr_en = 1'b1;
                w_term   = OPEN_TC;
                if (pass_sensor || w_tc) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DENY: begin
                w_tmr_en = 1'b1;
                w_term   = DENY_TC;
                if (w_tc) begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                w_tmr_en = 1'b1;
                w_term   = LOCK_TC;
                if (w_tc) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_fail <= '0;
        end else begin
            if ((r_state == ST_IDLE) && validate_code) begin
                r_code <= access_code;
            end
            if (r_state == ST_CHECK) begin
                r_fail <= w_code_ok ? '0 : w_fail_inc;
            end else if ((r_state == ST_LOCKOUT) && w_tc) begin
                r_fail <= '0;
            end
        end
    end

`ifdef TURNSTILE_PASS_COUNT_EN
    logic [PCNT_W-1:0] r_pass;

    // A sensor hit in OPEN always ends the phase, even on the expiry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= '0;
        end else if ((r_state == ST_OPEN) && pass_sensor && (r_pass != '1)) begin
            r_pass <= r_pass + 1'b1;
        end
    end

    assign pass_count = r_pass;
`endif

    assign open_access_door = (r_state == ST_OPEN);
    assign deny_led         = (r_state == ST_DENY);
    assign lockout          = (r_state == ST_LOCKOUT);
    assign fail_count       = r_fail;
    assign state_out        = r_state;

endmodule
